// File: rtl/orao_vram_arbiter_if.sv
// Bus bundle between the HDMI display stage / CPU (master) and the VRAM arbiter (slave).
// Display fetch port plus a CPU request/ready port with a separate read-valid return.
interface orao_vram_arbiter_if #(
    parameter int unsigned ADDR_W = 13
);
    logic [ADDR_W-1:0] dispAddr;
    logic [7:0]        dispData;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ready;
    logic [7:0]        cpu_rdata;
    logic              cpu_rvalid;

    modport master (
        output dispAddr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dispData, cpu_ready, cpu_rdata, cpu_rvalid
    );

    modport slave (
        input  dispAddr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dispData, cpu_ready, cpu_rdata, cpu_rvalid
    );
endinterface

// File: rtl/orao_vram_arbiter.sv
// Single-port video RAM shared by the display fetch (always wins) and a CPU port with posted writes.
// Optional macro VRAM_CLEAR_EN: zero the whole RAM after reset before accepting CPU traffic.
module orao_vram_arbiter #(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk_pixel,
    input  logic               reset_n,
    orao_vram_arbiter_if.slave bus
);
    localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned MemSize = 2 ** ADDR_W;

    typedef logic [PtrW:0] ptr_t;

    logic [7:0]        mem [MemSize];
    logic [7:0]        ram_q;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    ptr_t              wr_ptr_q, rd_ptr_q;
    logic              fifo_empty, fifo_full, push, pop;

    logic [ADDR_W-1:0] disp_last_q, rd_addr_q, clr_addr;
    logic              force_fetch_q, rd_pend_q;
    logic              trigger, rd_issue, rd_accept, clearing, clr_write;
    logic              disp_fetch_q, cpu_fetch_q;
    logic [7:0]        disp_data_q, cpu_rdata_q;
    logic              cpu_rvalid_q;

`ifdef VRAM_CLEAR_EN
    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // A display fetch owns the RAM port, so the clear counter simply stalls that cycle.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_write = 1'b0;
        unique case (state_q)
            StClear: begin
                if (!trigger) begin
                    clr_write = 1'b1;
                    clr_cnt_d = clr_cnt_q + (ADDR_W + 1)'(1);
                    if (clr_cnt_d[ADDR_W]) state_d = StRun;
                end
            end
            StRun: state_d = StRun;
        endcase
    end

    assign clearing = (state_q == StClear);
    assign clr_addr = clr_cnt_q[ADDR_W-1:0];
`else
    assign clearing  = 1'b0;
    assign clr_write = 1'b0;
    assign clr_addr  = '0;
`endif

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

    // Reads wait for an empty FIFO so they always observe every earlier posted write.
    assign bus.cpu_ready = !clearing &&
                           (bus.cpu_we ? !fifo_full : (fifo_empty && !rd_pend_q));
    assign push      = bus.cpu_req && bus.cpu_ready && bus.cpu_we;
    assign rd_accept = bus.cpu_req && bus.cpu_ready && !bus.cpu_we;

    assign trigger  = force_fetch_q || (bus.dispAddr != disp_last_q);
    assign rd_issue = !trigger && !clearing && rd_pend_q;
    assign pop      = !trigger && !clearing && !rd_pend_q && !fifo_empty;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = fifo_addr[rd_ptr_q[PtrW-1:0]];
        ram_wdata = fifo_data[rd_ptr_q[PtrW-1:0]];
        if (trigger) begin
            ram_addr = bus.dispAddr;
        end else if (clr_write) begin
            ram_we    = 1'b1;
            ram_addr  = clr_addr;
            ram_wdata = '0;
        end else if (rd_issue) begin
            ram_addr = rd_addr_q;
        end else if (pop) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else        ram_q         <= mem[ram_addr];
    end

    always_ff @(posedge clk_pixel) begin
        if (push) begin
            fifo_addr[wr_ptr_q[PtrW-1:0]] <= bus.cpu_addr;
            fifo_data[wr_ptr_q[PtrW-1:0]] <= bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            disp_last_q   <= '0;
            force_fetch_q <= 1'b1;
            rd_pend_q     <= 1'b0;
            rd_addr_q     <= '0;
            disp_fetch_q  <= 1'b0;
            cpu_fetch_q   <= 1'b0;
            disp_data_q   <= '0;
            cpu_rdata_q   <= '0;
            cpu_rvalid_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            if (trigger) begin
                disp_last_q   <= bus.dispAddr;
                force_fetch_q <= 1'b0;
            end
            if (rd_accept) begin
                rd_pend_q <= 1'b1;
                rd_addr_q <= bus.cpu_addr;
            end else if (rd_issue) begin
                rd_pend_q <= 1'b0;
            end
            // Second pipeline stage: route the registered RAM word to its requester.
            disp_fetch_q <= trigger;
            cpu_fetch_q  <= rd_issue;
            if (disp_fetch_q) disp_data_q <= ram_q;
            if (cpu_fetch_q)  cpu_rdata_q <= ram_q;
            cpu_rvalid_q <= cpu_fetch_q;
        end
    end

    assign bus.dispData   = disp_data_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
endmodule

// File: tb/tb_orao_vram_arbiter.sv
// Bench for orao_vram_arbiter: directed scenarios plus random traffic, all checked each cycle
// against a transaction-level model (memory array, write queue, pending read, two-stage returns).
module tb_orao_vram_arbiter;
    localparam int unsigned ADDR_W     = 13;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned MEM_SIZE   = 1 << ADDR_W;
    localparam int unsigned WIN        = 64;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef struct {
        addr_t      a;
        logic [7:0] d;
    } wr_t;

    logic clk_pixel = 1'b0;
    logic reset_n   = 1'b1;
    always #20 clk_pixel = ~clk_pixel;

    orao_vram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    orao_vram_arbiter #(
        .ADDR_W    (ADDR_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_mem   [MEM_SIZE];
    bit         m_known [MEM_SIZE];
    wr_t        m_q [$];
    bit         m_pend, m_force;
    addr_t      m_raddr, m_last;
    int         m_st1;  // 0 idle, 1 display word in flight, 2 CPU word in flight
    logic [7:0] m_st1_d, m_disp, m_rdata;
    bit         m_st1_k, m_disp_k, m_rdata_k, m_rvalid;
    addr_t      cur_da;
    bit         last_acc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready(input bit we);
        if (we) return m_q.size() < int'(FIFO_DEPTH);
        return (m_q.size() == 0) && !m_pend;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_pend    = 1'b0;
        m_force   = 1'b1;
        m_last    = '0;
        m_raddr   = '0;
        m_st1     = 0;
        m_disp    = 8'h00;
        m_disp_k  = 1'b1;
        m_rdata   = 8'h00;
        m_rdata_k = 1'b1;
        m_rvalid  = 1'b0;
    endtask

    task automatic model_edge(input bit req, input bit we, input addr_t a, input logic [7:0] d,
                              input addr_t da);
        bit  rdy;
        wr_t w;
        rdy = m_ready(we);
        if (m_st1 == 1) begin
            m_disp   = m_st1_d;
            m_disp_k = m_st1_k;
        end
        m_rvalid = (m_st1 == 2);
        if (m_st1 == 2) begin
            m_rdata   = m_st1_d;
            m_rdata_k = m_st1_k;
        end
        if (m_force || (da != m_last)) begin
            m_st1   = 1;
            m_st1_d = m_mem[da];
            m_st1_k = m_known[da];
            m_last  = da;
            m_force = 1'b0;
        end else if (m_pend) begin
            m_st1   = 2;
            m_st1_d = m_mem[m_raddr];
            m_st1_k = m_known[m_raddr];
            m_pend  = 1'b0;
        end else begin
            m_st1 = 0;
            if (m_q.size() > 0) begin
                w = m_q.pop_front();
                m_mem[w.a]   = w.d;
                m_known[w.a] = 1'b1;
            end
        end
        if (req && rdy) begin
            if (we) begin
                m_q.push_back('{a: a, d: d});
            end else begin
                m_pend  = 1'b1;
                m_raddr = a;
            end
        end
    endtask

    task automatic step(input bit req, input bit we, input addr_t a, input logic [7:0] d,
                        input addr_t da);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.dispAddr  = da;
        cur_da        = da;
        #1;
        check_val("cpu_ready", 32'(bus.cpu_ready), 32'(m_ready(we)));
        last_acc = req && m_ready(we);
        model_edge(req, we, a, d, da);
        @(posedge clk_pixel);
        #1;
        if (m_disp_k) check_val("dispData", 32'(bus.dispData), 32'(m_disp));
        check_val("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(m_rvalid));
        if (m_rdata_k) check_val("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_rdata));
        @(negedge clk_pixel);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 8'h00, cur_da);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (m_q.size() != 0 || m_pend || m_st1 != 0); i++) idle();
    endtask

    task automatic do_write(input addr_t a, input logic [7:0] d);
        int tries = 0;
        last_acc = 1'b0;
        while (!last_acc && tries < 40) begin
            step(1'b1, 1'b1, a, d, cur_da);
            tries++;
        end
        check_val("wr_accept", 32'(last_acc), 32'd1);
    endtask

    task automatic do_read(input addr_t a, output logic [7:0] data, output int waits,
                           output int lat);
        int tries = 0;
        bit got   = 1'b0;
        last_acc = 1'b0;
        data     = 8'h00;
        while (!last_acc && tries < 40) begin
            step(1'b1, 1'b0, a, 8'h00, cur_da);
            tries++;
        end
        check_val("rd_accept", 32'(last_acc), 32'd1);
        waits = tries - 1;
        lat   = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            idle();
            lat++;
            if (bus.cpu_rvalid) begin
                got  = 1'b1;
                data = bus.cpu_rdata;
            end
        end
        check_val("rd_rvalid", 32'(got), 32'd1);
    endtask

`ifdef VRAM_CLEAR_EN
    task automatic wait_clear();
        int cycles = 0;
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
        #1;
        while (!bus.cpu_ready && cycles < 20000) begin
            @(negedge clk_pixel);
            #1;
            cycles++;
        end
        check_val("clear_len", 32'(cycles >= 8192 && cycles < 20000), 32'd1);
        @(negedge clk_pixel);
        for (int i = 0; i < int'(MEM_SIZE); i++) begin
            m_mem[i]   = 8'h00;
            m_known[i] = 1'b1;
        end
        m_force  = 1'b0;
        m_last   = cur_da;
        m_disp_k = 1'b0;
    endtask
`endif

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] data, pre8, pre9;
        int         waits, lat, acc, rec;
        bit         exp_rdy;
        addr_t      da;

        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = 8'h00;
        bus.dispAddr  = '0;
        cur_da        = '0;
        for (int i = 0; i < int'(MEM_SIZE); i++) m_known[i] = 1'b0;
        m_reset();

`ifdef VRAM_CLEAR_EN
        exp_rdy = 1'b0;
`else
        exp_rdy = 1'b1;
`endif
        #2 reset_n = 1'b0;
        #2;
        check_val("rst_dispData", 32'(bus.dispData), 32'h0);
        check_val("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
        check_val("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
        check_val("rst_cpu_ready", 32'(bus.cpu_ready), 32'(exp_rdy));
        @(posedge clk_pixel);
        @(negedge clk_pixel);
        reset_n = 1'b1;
`ifdef VRAM_CLEAR_EN
        wait_clear();
`endif

        // Known contents in a small window so every later read is checkable.
        for (int i = 0; i < int'(WIN); i++) do_write(addr_t'(i), 8'($urandom));
        drain();

        // Posted writes then a coherent read of the first one.
        do_write(addr_t'(16'h0010), 8'hA5);
        do_write(addr_t'(16'h0011), 8'h3C);
        do_read(addr_t'(16'h0010), data, waits, lat);
        check_val("t1_rdata", 32'(data), 32'hA5);
        check_val("t1_wait", 32'(waits), 32'd1);
        check_val("t1_lat", 32'(lat), 32'd2);
        drain();

        // Display fetch latency is two edges even with the CPU hammering the port.
        do_write(addr_t'(16'h001F), 8'h11);
        do_write(addr_t'(16'h0020), 8'h81);
        drain();
        step(1'b0, 1'b0, '0, 8'h00, addr_t'(16'h001F));
        for (int i = 0; i < 3; i++) idle();
        step(1'b1, 1'b1, addr_t'(16'h0030), 8'($urandom), addr_t'(16'h0020));
        check_val("t2_edge1", 32'(bus.dispData), 32'h11);
        step(1'b1, 1'b1, addr_t'(16'h0031), 8'($urandom), addr_t'(16'h0020));
        check_val("t2_edge2", 32'(bus.dispData), 32'h81);
        drain();

        // Stall the drain with a moving display address until the FIFO fills.
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            da = (i % 2 == 1) ? addr_t'(16'h0002) : addr_t'(16'h0003);
            step(1'b1, 1'b1, addr_t'(16'h0038 + i), 8'($urandom), da);
            if (!last_acc) break;
            acc++;
        end
        check_val("t3_accepts", 32'(acc), 32'(FIFO_DEPTH));
        rec = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, addr_t'(16'h003C), 8'h77, cur_da);
            if (last_acc) break;
            rec++;
        end
        check_val("t3_recover", 32'(rec), 32'd1);
        drain();

        // Read blocked behind two queued writes, then sees the newest data.
        step(1'b1, 1'b1, addr_t'(16'h0005), 8'h5A, addr_t'(16'h0004));
        step(1'b1, 1'b1, addr_t'(16'h0006), 8'hC3, addr_t'(16'h0005));
        do_read(addr_t'(16'h0006), data, waits, lat);
        check_val("t4_rdata", 32'(data), 32'hC3);
        check_val("t4_wait", 32'(waits), 32'd2);
        drain();

        // Reset with queued writes and a pending read.
        pre8 = m_mem[8];
        pre9 = m_mem[9];
        step(1'b1, 1'b0, addr_t'(16'h000A), 8'h00, addr_t'(16'h0006));
        step(1'b1, 1'b1, addr_t'(16'h0008), ~pre8, addr_t'(16'h0007));
        step(1'b1, 1'b1, addr_t'(16'h0009), ~pre9, addr_t'(16'h0006));
        reset_n = 1'b0;
        #1;
        check_val("t5_dispData", 32'(bus.dispData), 32'h0);
        check_val("t5_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
        check_val("t5_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_pixel);
            #1;
            check_val("t5_no_rvalid", 32'(bus.cpu_rvalid), 32'h0);
        end
        @(negedge clk_pixel);
        reset_n = 1'b1;
        m_reset();
`ifdef VRAM_CLEAR_EN
        wait_clear();
        pre8 = 8'h00;
        pre9 = 8'h00;
`endif
        do_read(addr_t'(16'h0008), data, waits, lat);
        check_val("t5_mem8", 32'(data), 32'(pre8));
        do_read(addr_t'(16'h0009), data, waits, lat);
        check_val("t5_mem9", 32'(data), 32'(pre9));

        // Random mixed traffic.
        for (int i = 0; i < 1500; i++) begin
            da = ($urandom_range(0, 3) == 0) ? addr_t'($urandom_range(0, WIN - 1)) : cur_da;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 addr_t'($urandom_range(0, WIN - 1)), 8'($urandom), da);
        end
        drain();

`ifdef VRAM_CLEAR_EN
        for (int i = 0; i < int'(MEM_SIZE); i++) do_write(addr_t'(i), 8'hFF);
        drain();
        reset_n = 1'b0;
        @(posedge clk_pixel);
        @(negedge clk_pixel);
        reset_n = 1'b1;
        m_reset();
        wait_clear();
        do_read(addr_t'(16'h0000), data, waits, lat);
        check_val("clr_0000", 32'(data), 32'h00);
        do_read(addr_t'(16'h1000), data, waits, lat);
        check_val("clr_1000", 32'(data), 32'h00);
        do_read(addr_t'(16'h1FFF), data, waits, lat);
        check_val("clr_1fff", 32'(data), 32'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/orao_vram_arbiter.md
Name: orao_vram_arbiter

Overview:
- 8 KB single-port video RAM with arbitration between the bitmap display fetch port and a CPU access port.
- Sits directly upstream of the HDMI bitmap display: it consumes that stage's dispAddr and returns dispData.
- Runs entirely in the pixel clock domain. CPU-side signals arrive already synchronised to clk_pixel.
- Display reads always win. CPU writes are posted through a small FIFO so the CPU rarely stalls.

Parameters:
- ADDR_W, 13, RAM address width (2^ADDR_W bytes).
- FIFO_DEPTH, 4, posted-write FIFO entries (power of two, ≥2).

Ports:
- clk_pixel  in  1  pixel clock (25 MHz); all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- dispAddr  in  ADDR_W  display fetch address from the HDMI display stage.
- dispData  out  8  byte at dispAddr, registered.
- cpu_req  in  1  CPU request valid.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  8  CPU write data.
- cpu_ready  out  1  request accepted on the cycle where cpu_req && cpu_ready.
- cpu_rdata  out  8  read data, valid while cpu_rvalid is high.
- cpu_rvalid  out  1  one-cycle pulse per accepted read.

Behaviour:
- Reset values: dispData=0, cpu_rdata=0, cpu_rvalid=0, FIFO empty, disp_last=0, force_fetch=1. cpu_ready=1, or 0 while clearing (see Optional Feature).
- RAM: one port, synchronous read, one operation per cycle; read data is registered at the next edge.
- Display fetch trigger, evaluated each cycle:
  - trigger = force_fetch || (dispAddr != disp_last).
  - On trigger: RAM reads dispAddr this cycle; disp_last <= dispAddr; force_fetch <= 0.
  - dispData <= RAM output one cycle later.
  - Fixed latency: dispData reflects mem[dispAddr] exactly 2 edges after dispAddr changes. The display stage tolerates up to 15.
- Arbitration, one slot per cycle, highest priority first:
  1. display fetch;
  2. pending CPU read;
  3. FIFO head write.
  - A starved CPU read or write retries on the next free cycle.
- CPU write acceptance:
  - Accepted when cpu_we=1 and the FIFO is not full; the address/data pair is pushed.
  - cpu_ready = !fifo_full for writes.
- CPU read acceptance:
  - Accepted only when the FIFO is empty and no read is pending. This gives read-after-write coherence.
  - cpu_ready = fifo_empty && !rd_pend for reads, i.e. cpu_ready is combinational on cpu_we.
  - Accepted read latches cpu_addr and sets rd_pend.
  - When the read wins the slot: RAM read, rd_pend cleared, then cpu_rdata updated and cpu_rvalid pulsed 1 cycle later.
  - cpu_rdata holds its value until the next read.
- Latency (uncontended):
  - write: ≥1 cycle from accept to RAM;
  - read: cpu_rvalid 2 cycles after accept.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, but cpu_ready is computed from the pre-pop state. No bypass.
- A write to the address currently shown does not refresh dispData; it appears on the next fetch of that address.
- FIFO pointers wrap modulo FIFO_DEPTH; full/empty are tracked with an extra pointer bit.
- Reset asserted mid-operation:
  - FIFO contents and the pending read are discarded;
  - RAM contents are not altered, except by the clear feature;
  - outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro VRAM_CLEAR_EN.
- Defined:
  - After reset release, state CLEAR writes 0 to addresses 0..2^ADDR_W-1, one per cycle, using an ADDR_W+1-bit counter.
  - The display trigger still preempts; the clear counter stalls that cycle.
  - cpu_ready=0 throughout CLEAR.
  - Reaching the terminal count moves to state RUN and cpu_ready follows the normal rules.
  - CLEAR takes 8192 cycles plus the number of display-preempted cycles.
- Not defined:
  - No CLEAR state; RUN is entered at reset and RAM powers up with its init contents.

Test Plan:
- Write 0xA5 to 0x0010, write 0x3C to 0x0011, read 0x0010 → cpu_rvalid pulses with cpu_rdata=0xA5; FIFO drains in 2 free cycles.
- Preload mem[0x0020]=0x81 and step dispAddr 0x001F→0x0020 → dispData=0x81 exactly 2 edges later, even with cpu_req asserted every cycle.
- Hold cpu_req with writes and stall the drain by changing dispAddr every cycle → cpu_ready drops after 4 accepts and returns the cycle after the first pop.
- Issue a read while the FIFO holds 2 writes → cpu_ready=0 until the FIFO is empty; the read then returns the just-written value.
- Assert reset_n=0 while the FIFO is non-empty and a read is pending → outputs are 0 asynchronously, no cpu_rvalid pulse, and the discarded writes never reach RAM.
- With VRAM_CLEAR_EN: preload 0xFF everywhere, reset → cpu_ready low for ≥8192 cycles, then reads of 0x0000, 0x1000 and 0x1FFF return 0x00.
